// File: rtl/matrix_mult_ctrl_if.sv
// Host handshake plus single-port matrix RAM bus for the 3x3 matrix multiply sequencer.
// The master modport is the sequencer side; the slave modport is the host/RAM side.
interface matrix_mult_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 5
);
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_wren;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (
        input  start,
        input  mem_dout,
        output busy,
        output done,
        output mem_addr,
        output mem_wren,
        output mem_din
    );

    modport slave (
        output start,
        output mem_dout,
        input  busy,
        input  done,
        input  mem_addr,
        input  mem_wren,
        input  mem_din
    );
endinterface

// File: rtl/matrix_mult_ctrl.sv
// Sequencer for C = A*B on 3x3 matrices held in a shared single-port RAM.
// It loads A and B, multiply-accumulates one product per cycle, then writes C back.
module matrix_mult_ctrl #(
    parameter int DW     = 8,
    parameter int N      = 3,
    parameter int A_BASE = 0,
    parameter int B_BASE = 9,
    parameter int C_BASE = 18,
    parameter int AW     = 5,
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    matrix_mult_ctrl_if.master bus
);
    localparam int NN       = N * N;
    localparam int LOAD_CYC = 2 * NN + RD_LAT;
    localparam int ACC_W    = 2 * DW + 2;
    localparam int EW       = (NN > 1) ? $clog2(NN) : 1;
    localparam int IW       = (N > 1) ? $clog2(N) : 1;
    localparam int CW       = $clog2(LOAD_CYC);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        STORE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt, cnt_next;
    logic [IW-1:0]    i_idx, j_idx, k_idx;
    logic [IW-1:0]    i_next, j_next, k_next;
    logic [AW-1:0]    addr_q, addr_next;
    logic             wren_q, wren_next;
    logic [DW-1:0]    din_q, din_next;

    logic [DW-1:0]    a_file [NN];
    logic [DW-1:0]    b_file [NN];
    logic [DW-1:0]    c_file [NN];
    logic [ACC_W-1:0] acc;

    logic [DW-1:0]    a_sel, b_sel;
    logic [2*DW-1:0]  prod;
    logic [ACC_W-1:0] acc_base, acc_sum;

    // Load cycle c reads A element c first, then B element c-NN.
    function automatic logic [AW-1:0] load_addr(input int c);
        if (c < NN) begin
            return AW'(A_BASE + c);
        end
        return AW'(B_BASE + c - NN);
    endfunction

    assign bus.busy     = (state == LOAD) || (state == CALC) || (state == STORE);
    assign bus.done     = (state == DONE);
    assign bus.mem_addr = addr_q;
    assign bus.mem_wren = wren_q;
    assign bus.mem_din  = din_q;

    assign a_sel    = a_file[EW'(int'(i_idx) * N + int'(k_idx))];
    assign b_sel    = b_file[EW'(int'(k_idx) * N + int'(j_idx))];
    assign prod     = {{DW{1'b0}}, a_sel} * {{DW{1'b0}}, b_sel};
    assign acc_base = (k_idx == '0) ? '0 : acc;
    assign acc_sum  = acc_base + {{(ACC_W - 2*DW){1'b0}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            i_idx  <= '0;
            j_idx  <= '0;
            k_idx  <= '0;
            addr_q <= '0;
            wren_q <= 1'b0;
            din_q  <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            i_idx  <= i_next;
            j_idx  <= j_next;
            k_idx  <= k_next;
            addr_q <= addr_next;
            wren_q <= wren_next;
            din_q  <= din_next;
        end
    end

    // RAM outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        i_next     = i_idx;
        j_next     = j_idx;
        k_next     = k_idx;
        addr_next  = addr_q;
        wren_next  = 1'b0;
        din_next   = din_q;
        case (state)
            IDLE: begin
                addr_next = '0;
                if (bus.start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                    addr_next  = load_addr(0);
                end
            end
            LOAD: begin
                cnt_next = cnt + CW'(1);
                if (int'(cnt) < 2*NN - 1) begin
                    addr_next = load_addr(int'(cnt) + 1);
                end
                if (int'(cnt) == LOAD_CYC - 1) begin
                    state_next = CALC;
                    cnt_next   = '0;
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                end
            end
            CALC: begin
                k_next = k_idx + IW'(1);
                if (int'(k_idx) == N - 1) begin
                    k_next = '0;
                    j_next = j_idx + IW'(1);
                    if (int'(j_idx) == N - 1) begin
                        j_next = '0;
                        i_next = i_idx + IW'(1);
                        if (int'(i_idx) == N - 1) begin
                            i_next     = '0;
                            state_next = STORE;
                            cnt_next   = '0;
                            wren_next  = 1'b1;
                            addr_next  = AW'(C_BASE);
                            din_next   = c_file[0];
                        end
                    end
                end
            end
            STORE: begin
                if (int'(cnt) == NN - 1) begin
                    state_next = DONE;
                    cnt_next   = '0;
                    addr_next  = '0;
                    din_next   = '0;
                end else begin
                    cnt_next  = cnt + CW'(1);
                    wren_next = 1'b1;
                    addr_next = AW'(C_BASE + int'(cnt) + 1);
                    din_next  = c_file[EW'(int'(cnt) + 1)];
                end
            end
            DONE: begin
                state_next = IDLE;
                addr_next  = '0;
            end
            default: begin
                state_next = IDLE;
                addr_next  = '0;
            end
        endcase
    end

    // Word for load cycle c arrives RD_LAT cycles later; C keeps only the low DW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NN; e++) begin
                a_file[e] <= '0;
                b_file[e] <= '0;
                c_file[e] <= '0;
            end
            acc <= '0;
        end else begin
            if (state == LOAD && int'(cnt) >= RD_LAT) begin
                if (int'(cnt) - RD_LAT < NN) begin
                    a_file[EW'(int'(cnt) - RD_LAT)] <= bus.mem_dout;
                end else begin
                    b_file[EW'(int'(cnt) - RD_LAT - NN)] <= bus.mem_dout;
                end
            end
            if (state == CALC) begin
                acc <= acc_sum;
                if (int'(k_idx) == N - 1) begin
                    c_file[EW'(int'(i_idx) * N + int'(j_idx))] <= acc_sum[DW-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Self-checking bench for matrix_mult_ctrl: RAM model with 2-cycle read latency,
// C-write scoreboard fed from an integer matrix model.
module tb_matrix_mult_ctrl;
    localparam int DW     = 8;
    localparam int N      = 3;
    localparam int NN     = 9;
    localparam int A_BASE = 0;
    localparam int B_BASE = 9;
    localparam int C_BASE = 18;
    localparam int AW     = 5;
    localparam int RD_LAT = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_mult_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    matrix_mult_ctrl #(
        .DW(DW), .N(N), .A_BASE(A_BASE), .B_BASE(B_BASE),
        .C_BASE(C_BASE), .AW(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    wr_t           exp_q[$];
    logic [DW-1:0] ram [32];
    logic [DW-1:0] rd1, rd2;
    int            mat_a [NN];
    int            mat_b [NN];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            wr_count = 0;
    int            first_wr = -1;
    int            last_wr  = -1;

    assign bus.mem_dout = rd2;

    // RAM: read-before-write, two pipeline stages of read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd1 <= ram[bus.mem_addr];
        rd2 <= rd1;
        if (bus.mem_wren) ram[bus.mem_addr] = bus.mem_din;
    end

    // Scoreboard: every RAM write must be the next expected C element.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.mem_wren) begin
            wr_count++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            checks++;
            if (bus.mem_addr < AW'(C_BASE)) begin
                failures++;
                $display("[TB] FAIL write_protect addr=%0d required>=%0d", bus.mem_addr, C_BASE);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write addr=%0d data=%0d required=no write", bus.mem_addr, bus.mem_din);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_din !== e.data) begin
                    failures++;
                    $display("[TB] FAIL c_write got addr=%0d data=%0d required addr=%0d data=%0d",
                             bus.mem_addr, bus.mem_din, e.addr, e.data);
                end
            end
        end
    end

    task automatic load_and_expect();
        int  sum;
        wr_t e;
        for (int x = 0; x < NN; x++) begin
            ram[A_BASE + x] = DW'(mat_a[x]);
            ram[B_BASE + x] = DW'(mat_b[x]);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = 0;
                for (int k = 0; k < N; k++) sum += mat_a[i*N + k] * mat_b[k*N + j];
                e.addr = AW'(C_BASE + i*N + j);
                e.data = DW'(sum % 256);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(output int t_ref);
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        t_ref = cyc;
    endtask

    task automatic wait_done(input int t_ref, input int limit, output int done_off, output int busy_cnt);
        done_off = -1;
        busy_cnt = 0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_off = cyc - t_ref + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b required=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b required=0", bus.done); end
        checks++; if (bus.mem_wren !== 1'b0) begin failures++; $display("[TB] FAIL reset_wren got=%b required=0", bus.mem_wren); end
        checks++; if (bus.mem_addr !== '0) begin failures++; $display("[TB] FAIL reset_addr got=%0d required=0", bus.mem_addr); end
        checks++; if (bus.mem_din !== '0) begin failures++; $display("[TB] FAIL reset_din got=%0d required=0", bus.mem_din); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b required=0", bus.busy); end
    endtask

    task automatic test_basic();
        int            t_ref, done_off, busy_cnt, wr0;
        logic [DW-1:0] c_ref [NN];
        c_ref = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        mat_a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mat_b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_and_expect();
        wr0 = wr_count; first_wr = -1; last_wr = -1;
        pulse_start(t_ref);
        wait_done(t_ref, 100, done_off, busy_cnt);
        checks++; if (done_off !== 57) begin failures++; $display("[TB] FAIL basic_done_time got=%0d required=57", done_off); end
        checks++; if (busy_cnt !== 56) begin failures++; $display("[TB] FAIL basic_busy_cycles got=%0d required=56", busy_cnt); end
        checks++; if (first_wr - t_ref + 1 !== 48) begin failures++; $display("[TB] FAIL basic_first_write got=%0d required=48", first_wr - t_ref + 1); end
        checks++; if (last_wr - t_ref + 1 !== 56) begin failures++; $display("[TB] FAIL basic_last_write got=%0d required=56", last_wr - t_ref + 1); end
        checks++; if (wr_count - wr0 !== 9) begin failures++; $display("[TB] FAIL basic_write_count got=%0d required=9", wr_count - wr0); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_after_done got done=%b busy=%b required 0 0", bus.done, bus.busy); end
        for (int e = 0; e < NN; e++) begin
            checks++;
            if (ram[C_BASE + e] !== c_ref[e]) begin
                failures++;
                $display("[TB] FAIL basic_ram_c%0d got=%0d required=%0d", e, ram[C_BASE + e], c_ref[e]);
            end
        end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL basic_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_identity();
        int t_ref, done_off, busy_cnt, wr0;
        mat_a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mat_b = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        load_and_expect();
        wr0 = wr_count;
        pulse_start(t_ref);
        wait_done(t_ref, 100, done_off, busy_cnt);
        checks++; if (done_off !== 57) begin failures++; $display("[TB] FAIL ident_done_time got=%0d required=57", done_off); end
        checks++; if (wr_count - wr0 !== 9) begin failures++; $display("[TB] FAIL ident_write_count got=%0d required=9", wr_count - wr0); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL ident_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_saturate();
        int t_ref, done_off, busy_cnt, wr0;
        for (int x = 0; x < NN; x++) begin
            mat_a[x] = 255;
            mat_b[x] = 255;
        end
        load_and_expect();
        wr0 = wr_count;
        pulse_start(t_ref);
        wait_done(t_ref, 100, done_off, busy_cnt);
        checks++; if (done_off !== 57) begin failures++; $display("[TB] FAIL sat_done_time got=%0d required=57", done_off); end
        checks++; if (wr_count - wr0 !== 9) begin failures++; $display("[TB] FAIL sat_write_count got=%0d required=9", wr_count - wr0); end
        checks++; if (ram[C_BASE + 4] !== 8'd3) begin failures++; $display("[TB] FAIL sat_c4 got=%0d required=3", ram[C_BASE + 4]); end
    endtask

    task automatic test_ignored_start();
        int t_ref, wr0, dones, done_off;
        mat_a = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
        mat_b = '{2, 7, 1, 8, 2, 8, 1, 8, 2};
        load_and_expect();
        wr0 = wr_count; dones = 0; done_off = -1;
        pulse_start(t_ref);
        for (int n = 1; n <= 130; n++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                done_off = n;
            end
            bus.start = (n == 5 || n == 50);
        end
        bus.start = 1'b0;
        checks++; if (dones !== 1) begin failures++; $display("[TB] FAIL ign_done_pulses got=%0d required=1", dones); end
        checks++; if (done_off !== 57) begin failures++; $display("[TB] FAIL ign_done_time got=%0d required=57", done_off); end
        checks++; if (wr_count - wr0 !== 9) begin failures++; $display("[TB] FAIL ign_write_count got=%0d required=9", wr_count - wr0); end
    endtask

    task automatic test_mid_reset();
        int t_ref, done_off, busy_cnt, wr0;
        mat_a = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        mat_b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_and_expect();
        wr0 = wr_count;
        pulse_start(t_ref);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b required=0", bus.busy); end
        checks++; if (bus.mem_wren !== 1'b0) begin failures++; $display("[TB] FAIL midrst_wren got=%b required=0", bus.mem_wren); end
        checks++; if (bus.mem_addr !== '0) begin failures++; $display("[TB] FAIL midrst_addr got=%0d required=0", bus.mem_addr); end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        checks++; if (wr_count !== wr0) begin failures++; $display("[TB] FAIL midrst_no_writes got=%0d required=%0d", wr_count, wr0); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_stays_idle got=%b required=0", bus.busy); end
        load_and_expect();
        pulse_start(t_ref);
        wait_done(t_ref, 100, done_off, busy_cnt);
        checks++; if (done_off !== 57) begin failures++; $display("[TB] FAIL midrst_rerun_done got=%0d required=57", done_off); end
        checks++; if (wr_count - wr0 !== 9) begin failures++; $display("[TB] FAIL midrst_rerun_writes got=%0d required=9", wr_count - wr0); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL midrst_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int wr0, ndone;
        int done_cyc [2];
        bit rewrite;
        mat_a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mat_b = '{1, 0, 2, 0, 1, 0, 3, 0, 1};
        load_and_expect();
        wr0 = wr_count; ndone = 0; rewrite = 1'b0;
        done_cyc[0] = 0; done_cyc[1] = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        for (int n = 0; n < 200 && ndone < 2; n++) begin
            @(negedge clk);
            if (rewrite) begin
                rewrite = 1'b0;
                mat_a = '{2, 0, 1, 1, 3, 0, 0, 1, 4};
                load_and_expect();
            end
            if (bus.done) begin
                done_cyc[ndone] = cyc;
                ndone++;
                if (ndone == 1) rewrite = 1'b1;
                else bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checks++; if (ndone !== 2) begin failures++; $display("[TB] FAIL b2b_done_pulses got=%0d required=2", ndone); end
        checks++; if (done_cyc[1] - done_cyc[0] !== 58) begin failures++; $display("[TB] FAIL b2b_done_gap got=%0d required=58", done_cyc[1] - done_cyc[0]); end
        checks++; if (wr_count - wr0 !== 18) begin failures++; $display("[TB] FAIL b2b_write_count got=%0d required=18", wr_count - wr0); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL b2b_pending got=%0d required=0", exp_q.size()); end
        repeat (70) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_third_run got=%b required=0", bus.busy); end
    endtask

    initial begin
        bus.start = 1'b0;
        for (int x = 0; x < 32; x++) ram[x] = '0;
        test_reset();
        test_basic();
        test_identity();
        test_saturate();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
